// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
//
// Byte-serial multi-byte add/subtract sequencer. It drives one external 8-bit
// adder (a, b, carry-in -> sum, carry-out) for NBYTES cycles, LSB byte first.
// The carry is chained through a register. The full result is published in
// one step, together with a single-cycle done pulse.
//
// Operation: A + B + iC when iSub = 0, or A - B when iSub = 1. Subtraction is
// done as A + ~B + 1.
//
// Parameters:
//   NBYTES      number of operand bytes (2..16); data width is 8*NBYTES
//
// Optional feature (macro):
//   ADDER_SEQ_OVF_EN  adds oOverflow, the signed two's-complement overflow of
//                     the last completed operation
//
// Ports:
//   iClk, iRst       clock (rising edge), asynchronous active-high reset
//   iStart           start request, sampled only while idle
//   iSub, iC         subtract select, carry-in for add (ignored for subtract)
//   iData_a/b        wide operands, sampled only at the start edge
//   oBusy            high while the byte sequence runs
//   oDone            one-cycle pulse when oData / oData_C are updated
//   oData, oData_C   result and final carry-out (subtract: 1 = no borrow)
//   oOverflow        (ADDER_SEQ_OVF_EN only) signed overflow of the result
//   oAdd_a/b/C       byte operands and carry-in to the shared adder
//   iAdd_sum/C       sum and carry-out from the shared adder
// -----------------------------------------------------------------------------
module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iSub,
  input  logic                iC,
  input  logic [8*NBYTES-1:0] iData_a,
  input  logic [8*NBYTES-1:0] iData_b,
  output logic                oBusy,
  output logic                oDone,
  output logic [8*NBYTES-1:0] oData,
  output logic                oData_C,
`ifdef ADDER_SEQ_OVF_EN
  output logic                oOverflow,
`endif
  output logic [7:0]          oAdd_a,
  output logic [7:0]          oAdd_b,
  output logic                oAdd_C,
  input  logic [7:0]          iAdd_sum,
  input  logic                iAdd_C
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;         // already inverted for subtract
  logic [W-1:0]    r_res;       // partial result, built byte by byte
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            w_start;
  logic            w_last;
  logic [W-1:0]    w_res_next;

  assign w_start = (r_state == S_IDLE) && iStart;
  assign w_last  = (r_state == S_RUN) && (r_idx == IDXW'(NBYTES - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments. All flops then update
  // together, so process order cannot change what each flop samples.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top covers every path, so no latch is
  // inferred for w_state_next.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (iStart) w_state_next = S_RUN;
      S_RUN:  if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The adder inputs are forced to 0 while idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    oBusy  = 1'b0;
    oAdd_a = '0;
    oAdd_b = '0;
    oAdd_C = 1'b0;
    if (r_state == S_RUN) begin
      oBusy  = 1'b1;
      oAdd_a = r_a[{r_idx, 3'b000} +: 8];
      oAdd_b = r_b[{r_idx, 3'b000} +: 8];
      oAdd_C = r_carry;
    end
  end

  // Partial result with the byte that the adder is producing right now
  // merged in. oData takes this at the final edge, so the last byte is
  // included without ever showing a partial value.
  always_comb begin
    w_res_next = r_res;
    w_res_next[{r_idx, 3'b000} +: 8] = iAdd_sum;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand and result registers are reset as well. They are small,
  // and an abort must clear oData.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      oData     <= '0;
      oData_C   <= 1'b0;
      oDone     <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      oOverflow <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      if (w_start) begin
        r_a     <= iData_a;
        r_b     <= iSub ? ~iData_b : iData_b;
        r_carry <= iSub ? 1'b1 : iC;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        r_res   <= w_res_next;
        r_carry <= iAdd_C;
        r_idx   <= r_idx + IDXW'(1);
        if (w_last) begin
          oData   <= w_res_next;
          oData_C <= iAdd_C;
          oDone   <= 1'b1;
`ifdef ADDER_SEQ_OVF_EN
          // The carry into the MSB is a ^ b ^ sum at that bit. Overflow is
          // that carry XOR the carry out of the MSB.
          oOverflow <= r_a[W-1] ^ r_b[W-1] ^ iAdd_sum[7] ^ iAdd_C;
`endif
        end
      end
    end
  end

endmodule
